// File: rtl/otl_dac_core.sv
// otl_dac_core: DMA-fed transmit sample engine. Fetches 32-bit words over a
// request/response read port under a credit limit, buffers them in a word
// FIFO and unpacks each word into two 12-bit samples on a valid/ready stream.
module otl_dac_core #(
  parameter int ADDRW      = 32,
  parameter int DATAW      = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [ADDRW-1:0] start_addr,
  input  logic [15:0]      num_words,
  output logic             busy,
  output logic             done,
  output logic             underrun,
  output logic [ADDRW-1:0] dma_rdaddr,
  output logic             dma_rdvalid,
  input  logic             dma_rdready,
  input  logic [DATAW-1:0] dma_rddata,
  input  logic             dma_rddvalid,
  output logic [11:0]      tx_data,
  output logic             tx_frame,
  output logic             tx_valid,
  input  logic             tx_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, ABORT} state_t;
  state_t state_reg, state_next;

  logic [15:0]   num_words_reg;
  logic [15:0]   words_req_reg;
  logic [16:0]   samples_sent_reg;
  logic [CW-1:0] fifo_count_reg;
  logic [CW-1:0] outstanding_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [23:0]   fifo_mem [FIFO_DEPTH];
  logic [11:0]   hi_reg;
  logic          have_hi_reg;

  logic          active, start_ok, req_fire, tx_fire, push, pop, tx_slot;
  logic          last_req, last_sample, abort_exit, underrun_cond, rdvalid_next;
  logic [16:0]   total_samples;
  logic [15:0]   words_req_next;
  logic [CW-1:0] fifo_count_next, outstanding_next;
  logic [CW:0]   credit_next;
  logic          unused_bits;

  // Discarded nibbles of each word and the ignored address byte-offset bits.
  assign unused_bits = ^{dma_rddata[DATAW-1:28], dma_rddata[15:12], start_addr[1:0]};

  assign active           = (state_reg == FETCH) || (state_reg == DRAIN);
  assign start_ok         = (state_reg == IDLE) && start && enable;
  assign req_fire         = dma_rdvalid && dma_rdready;
  assign tx_fire          = tx_valid && tx_ready;
  assign push             = active && dma_rddvalid;
  // A new sample may be loaded only while running and the output slot frees up.
  assign tx_slot          = active && enable && (!tx_valid || tx_ready);
  assign pop              = tx_slot && !have_hi_reg && (fifo_count_reg != '0);
  assign total_samples    = {num_words_reg, 1'b0};
  assign words_req_next   = words_req_reg + {15'd0, req_fire};
  assign last_req         = req_fire && (words_req_next == num_words_reg);
  assign last_sample      = tx_fire && ((samples_sent_reg + 17'd1) == total_samples);
  assign abort_exit       = (outstanding_reg == '0) && !dma_rdvalid && !tx_valid;
  assign underrun_cond    = (samples_sent_reg != '0) && (samples_sent_reg < total_samples) &&
                            tx_ready && !tx_valid;
  assign fifo_count_next  = fifo_count_reg + CW'(push) - CW'(pop);
  assign outstanding_next = outstanding_reg + CW'(req_fire) -
                            CW'(dma_rddvalid && (outstanding_reg != '0));
  assign credit_next      = {1'b0, fifo_count_next} + {1'b0, outstanding_next};

  // Request valid is registered; it is computed from next-cycle credit so the
  // FIFO can never be oversubscribed, and a presented request is never withdrawn.
  assign rdvalid_next = start_ok ? (num_words != '0) :
                        ((dma_rdvalid && !dma_rdready) ||
                         ((state_next == FETCH) && (words_req_next < num_words_reg) &&
                          (credit_next < (CW+1)'(FIFO_DEPTH))));

  // State register.
  always_ff @(posedge sys_clk) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok && (num_words != '0)) state_next = FETCH;
      FETCH:   if (!enable) state_next = ABORT;
               else if (last_req) state_next = DRAIN;
      DRAIN:   if (!enable) state_next = ABORT;
               else if (last_sample) state_next = IDLE;
      ABORT:   if (abort_exit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transfer control: parameters, request address/valid, progress counters, status.
  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      busy             <= 1'b0;
      done             <= 1'b0;
      underrun         <= 1'b0;
      dma_rdaddr       <= '0;
      dma_rdvalid      <= 1'b0;
      num_words_reg    <= '0;
      words_req_reg    <= '0;
      samples_sent_reg <= '0;
      outstanding_reg  <= '0;
    end else begin
      done            <= 1'b0;
      dma_rdvalid     <= rdvalid_next;
      outstanding_reg <= outstanding_next;
      if (start_ok) begin
        num_words_reg    <= num_words;
        words_req_reg    <= '0;
        samples_sent_reg <= '0;
        underrun         <= 1'b0;
        dma_rdaddr       <= {start_addr[ADDRW-1:2], 2'b00};
        busy             <= (num_words != '0);
        done             <= (num_words == '0);
      end else begin
        if (req_fire) begin
          dma_rdaddr    <= dma_rdaddr + ADDRW'(4);
          words_req_reg <= words_req_next;
        end
        if (tx_fire) samples_sent_reg <= samples_sent_reg + 17'd1;
        if (active && underrun_cond) underrun <= 1'b1;
        if ((state_reg == DRAIN) && enable && last_sample) begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        if ((state_reg == ABORT) && abort_exit) busy <= 1'b0;
      end
    end
  end

  // Word FIFO storage; only the two sample fields of each word are kept.
  always_ff @(posedge sys_clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {dma_rddata[27:16], dma_rddata[11:0]};
  end

  // FIFO pointers and occupancy; flushed when an abort completes.
  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else if ((state_reg == ABORT) && abort_exit) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      fifo_count_reg <= fifo_count_next;
    end
  end

  // Unpacker: low half with frame marker first, then the held high half.
  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      tx_frame    <= 1'b0;
      hi_reg      <= '0;
      have_hi_reg <= 1'b0;
    end else if (state_reg == ABORT) begin
      if (tx_ready) tx_valid <= 1'b0;
      if (abort_exit) have_hi_reg <= 1'b0;
    end else if (tx_slot) begin
      if (have_hi_reg) begin
        tx_data     <= hi_reg;
        tx_frame    <= 1'b0;
        tx_valid    <= 1'b1;
        have_hi_reg <= 1'b0;
      end else if (fifo_count_reg != '0) begin
        tx_data     <= fifo_mem[rd_ptr_reg][11:0];
        hi_reg      <= fifo_mem[rd_ptr_reg][23:12];
        tx_frame    <= 1'b1;
        tx_valid    <= 1'b1;
        have_hi_reg <= 1'b1;
      end else begin
        tx_valid <= 1'b0;
      end
    end else if (tx_fire) begin
      tx_valid <= 1'b0;
    end
  end
endmodule

// File: doc/otl_dac_core.md
# otl_dac_core

DMA-fed transmit sample engine, the outbound counterpart of the ADC capture path. Fetches 32-bit words from memory over a DMA read request/response interface, buffers them in an internal FIFO, and unpacks each word into two 12-bit samples delivered on a valid/ready stream with a frame marker. Sits between the system DMA read port and the DAC serializer; all logic runs in the `sys_clk` domain.

## Interface

- `ADDRW`, 32, DMA address width.
- `DATAW`, 32, DMA data width; fixed at 32.
- `FIFO_DEPTH`, 16, word FIFO depth; power of two, ≥4.

- `sys_clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `enable`  in  1  core enable, from the config block; low aborts a transfer.
- `start`  in  1  one-cycle pulse; latches `start_addr` and `num_words`.
- `start_addr`  in  ADDRW  byte address of first word; bits [1:0] ignored (treated as 0).
- `num_words`  in  16  number of 32-bit words to transmit.
- `busy`  out  1  high from accepted `start` until return to IDLE.
- `done`  out  1  one-cycle pulse on normal completion.
- `underrun`  out  1  sticky; cleared by accepted `start`.
- `dma_rdaddr`  out  ADDRW  request address.
- `dma_rdvalid`  out  1  request valid.
- `dma_rdready`  in  1  request accepted when `dma_rdvalid` and `dma_rdready` are both high.
- `dma_rddata`  in  DATAW  response data, returned in request order.
- `dma_rddvalid`  in  1  response strobe; one word per cycle; no backpressure.
- `tx_data`  out  12  sample.
- `tx_frame`  out  1  high on first sample of each word.
- `tx_valid`  out  1  sample valid.
- `tx_ready`  in  1  sink ready.

## Operation

- FSM states: IDLE, FETCH, DRAIN, ABORT.
- IDLE: `start` with `enable=1` latches parameters and clears `underrun`.
  - If `num_words != 0`: go to FETCH and set `busy`.
  - If `num_words == 0`: pulse `done` next cycle, issue no requests, stay in IDLE.
  - `start` while not IDLE is ignored.
- FETCH issues requests.
  - Address starts at `start_addr` and increments by 4 per accepted request; wraps modulo 2^ADDRW.
  - Credit rule: `dma_rdvalid` is high only when `fifo_count + outstanding < FIFO_DEPTH` and requests remain.
  - `outstanding` increments on request accept and decrements on `dma_rddvalid`. Both on the same cycle: net 0.
  - `dma_rdaddr` is held stable while `dma_rdvalid & !dma_rdready`.
  - After the last request is accepted, go to DRAIN.
- Each `dma_rddvalid` pushes `dma_rddata` into the FIFO. Overflow is impossible by the credit rule.
- Unpacker pops one word and emits two samples:
  - Sample 0: `word[11:0]` with `tx_frame=1`.
  - Sample 1: `word[27:16]` with `tx_frame=0`.
  - Bits [15:12] and [31:28] are discarded.
- `tx_data`, `tx_frame` and `tx_valid` are held stable while `tx_valid & !tx_ready`.
- DRAIN: when all words have been emitted (2·`num_words` sample handshakes), pulse `done` and go to IDLE.
- `underrun` sets in FETCH or DRAIN on any cycle where all of these hold:
  - at least one sample has already been sent,
  - samples remain,
  - `tx_ready=1`,
  - `tx_valid=0`.
- `enable` low in FETCH or DRAIN: go to ABORT.
  - Issue no new requests; `dma_rdvalid` drops the next cycle unless it is mid-handshake. A request already presented stays asserted until accepted, then counts as outstanding.
  - Stop `tx_valid` after any pending sample handshake completes.
  - Discard responses until `outstanding == 0`, flush FIFO and unpacker, go to IDLE.
  - No `done` pulse; `busy` falls on entry to IDLE.
- Counters: 16-bit words-requested and 17-bit samples-sent counters; `log2(FIFO_DEPTH)+1`-bit `fifo_count` and `outstanding`.

## Timing

- Reset values (while `reset=0`):
  - state IDLE;
  - `busy`, `done`, `underrun`, `dma_rdvalid`, `tx_valid`, `tx_frame` = 0;
  - `dma_rdaddr`, `tx_data` = 0;
  - FIFO empty; all counters 0.
- Reset mid-transfer abandons everything immediately; late responses arriving after reset are ignored (still IDLE).
- Cycle 0: `start` sampled. Cycle 1: `busy=1`, `dma_rdvalid=1`, `dma_rdaddr=start_addr`.
- Response at cycle N: word is in the FIFO at N+1; earliest `tx_valid` (sample 0) at N+2.
- With `tx_ready` held high, samples stream one per cycle. Sustained rate is 2 samples per word, so the fetch path needs ≥0.5 word/cycle.
- `done` asserts the cycle after the final sample handshake; `busy` falls the same cycle.
- A new `start` is accepted from the cycle `busy` is low.

## Test plan

- Basic transfer:
  - Stimulus: `start_addr=0x1000`, `num_words=3`; memory returns 0x0ABC0123, 0x0FFF0000, 0x05550AAA with 2-cycle latency; `tx_ready=1`.
  - Required: requests at 0x1000/0x1004/0x1008; samples 0x123,0xABC,0x000,0xFFF,0xAAA,0x555; `tx_frame` pattern 1,0,1,0,1,0; single `done`; `underrun=0`.
- Backpressure:
  - Stimulus: `tx_ready` toggles every cycle; `dma_rdready` low for 5 cycles; `num_words=40`.
  - Required: no sample lost or duplicated; `dma_rdaddr` and `tx_data` stable while stalled; `outstanding+fifo_count ≤ 16` always.
- Underrun:
  - Stimulus: response latency 20 cycles, `tx_ready=1`, `num_words=4`.
  - Required: `underrun=1` after the first word drains; all 8 samples still delivered; `done` pulses; next `start` clears `underrun`.
- Zero length:
  - Stimulus: `num_words=0`.
  - Required: `done` one cycle later; no `dma_rdvalid`; `busy` stays 0.
- Abort:
  - Stimulus: drop `enable` with 3 requests outstanding.
  - Required: no new requests; 3 responses absorbed; return to IDLE with no `done`; a fresh transfer afterwards is correct.
- Reset:
  - Stimulus: assert `reset=0` mid-FETCH for 1 cycle.
  - Required: all outputs at reset values the next cycle.
